// File: rtl/ahb_slave_resp_mux_if.sv
// AHB-Lite bus bundle between the masters' side and the slave decoder/response mux.
// The slave modport is the mux's view; the master modport drives addresses and slave responses.
interface ahb_slave_resp_mux_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HSEL_S0;
    logic        HSEL_S1;
    logic        HSEL_S2;
    logic        HSEL_S3;
    logic        HREADYOUT_S0;
    logic        HREADYOUT_S1;
    logic        HREADYOUT_S2;
    logic        HREADYOUT_S3;
    logic [31:0] HRDATA_S0;
    logic [31:0] HRDATA_S1;
    logic [31:0] HRDATA_S2;
    logic [31:0] HRDATA_S3;
    logic [1:0]  HRESP_S0;
    logic [1:0]  HRESP_S1;
    logic [1:0]  HRESP_S2;
    logic [1:0]  HRESP_S3;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    modport slave (
        input  HADDR, HTRANS,
        input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
        input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
        input  HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3,
        output HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3,
        output HREADY, HRDATA, HRESP
    );

    modport master (
        output HADDR, HTRANS,
        output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
        output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
        output HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3,
        input  HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3,
        input  HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_slave_resp_mux.sv
// AHB-Lite slave decoder and data-phase response mux. Define DEFAULT_SLAVE_EN to build the
// internal default slave (two-cycle ERROR for unmapped transfers); otherwise unmapped goes to slave 0.
module ahb_slave_resp_mux #(
    parameter logic [3:0] S0_REGION = 4'h0,
    parameter logic [3:0] S1_REGION = 4'h1,
    parameter logic [3:0] S2_REGION = 4'h2,
    parameter logic [3:0] S3_REGION = 4'h3
) (
    input logic                 HCLK,
    input logic                 HRESET,
    ahb_slave_resp_mux_if.slave bus
);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

`ifdef DEFAULT_SLAVE_EN
    typedef enum logic [2:0] {SEL_S0, SEL_S1, SEL_S2, SEL_S3, SEL_DEF} sel_t;
    localparam sel_t SEL_FALLBACK = SEL_DEF;
`else
    typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_S2, SEL_S3} sel_t;
    localparam sel_t SEL_FALLBACK = SEL_S0;
`endif

    sel_t        dec_sel;
    sel_t        dsel;
    logic [3:0]  region;
    logic        hready;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        unused_bits;

    assign region = bus.HADDR[31:28];

    // Priority decode: on overlapping regions the lowest slave index wins.
    always_comb begin
        dec_sel = SEL_FALLBACK;
        if (region == S0_REGION)      dec_sel = SEL_S0;
        else if (region == S1_REGION) dec_sel = SEL_S1;
        else if (region == S2_REGION) dec_sel = SEL_S2;
        else if (region == S3_REGION) dec_sel = SEL_S3;
    end

    assign bus.HSEL_S0 = (dec_sel == SEL_S0);
    assign bus.HSEL_S1 = (dec_sel == SEL_S1);
    assign bus.HSEL_S2 = (dec_sel == SEL_S2);
    assign bus.HSEL_S3 = (dec_sel == SEL_S3);

    // The data-phase select only advances when the bus accepts the address phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel <= SEL_FALLBACK;
        end else if (hready) begin
            dsel <= dec_sel;
        end
    end

`ifdef DEFAULT_SLAVE_EN
    typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

    dstate_t dstate;
    dstate_t dstate_next;
    logic    err_start;

    assign err_start   = hready && (dec_sel == SEL_DEF) && bus.HTRANS[1];
    assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[27:0]};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dstate <= D_IDLE;
        end else begin
            dstate <= dstate_next;
        end
    end

    // ERR2 may chain straight into a new ERR1 so back-to-back errors have no gap.
    always_comb begin
        dstate_next = dstate;
        case (dstate)
            D_IDLE:  if (err_start) dstate_next = D_ERR1;
            D_ERR1:  dstate_next = D_ERR2;
            D_ERR2:  dstate_next = err_start ? D_ERR1 : D_IDLE;
            default: dstate_next = D_IDLE;
        endcase
    end
`else
    assign unused_bits = ^{bus.HTRANS, bus.HADDR[27:0]};
`endif

    always_comb begin
        hready = 1'b1;
        hrdata = '0;
        hresp  = RESP_OKAY;
        case (dsel)
            SEL_S0: begin
                hready = bus.HREADYOUT_S0;
                hrdata = bus.HRDATA_S0;
                hresp  = bus.HRESP_S0;
            end
            SEL_S1: begin
                hready = bus.HREADYOUT_S1;
                hrdata = bus.HRDATA_S1;
                hresp  = bus.HRESP_S1;
            end
            SEL_S2: begin
                hready = bus.HREADYOUT_S2;
                hrdata = bus.HRDATA_S2;
                hresp  = bus.HRESP_S2;
            end
            SEL_S3: begin
                hready = bus.HREADYOUT_S3;
                hrdata = bus.HRDATA_S3;
                hresp  = bus.HRESP_S3;
            end
`ifdef DEFAULT_SLAVE_EN
            SEL_DEF: begin
                hready = (dstate != D_ERR1);
                hresp  = (dstate == D_IDLE) ? RESP_OKAY : RESP_ERROR;
            end
`endif
            default: begin
                hready = 1'b1;
            end
        endcase
    end

    assign bus.HREADY = hready;
    assign bus.HRDATA = hrdata;
    assign bus.HRESP  = hresp;
endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// Directed self-checking bench for ahb_slave_resp_mux; covers both DEFAULT_SLAVE_EN builds.
module tb_ahb_slave_resp_mux;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic HCLK;
    logic HRESET;
    int   n_compared;
    int   n_mismatched;

    ahb_slave_resp_mux_if bus ();

    ahb_slave_resp_mux dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    function automatic logic [31:0] sel_vec();
        return {28'b0, bus.HSEL_S3, bus.HSEL_S2, bus.HSEL_S1, bus.HSEL_S0};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic [1:0] trans);
        bus.HADDR  = addr;
        bus.HTRANS = trans;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        HRESET           = 1'b1;
        bus.HREADYOUT_S0 = 1'b1;
        bus.HREADYOUT_S1 = 1'b1;
        bus.HREADYOUT_S2 = 1'b1;
        bus.HREADYOUT_S3 = 1'b1;
        bus.HRDATA_S0    = 32'h0000_A000;
        bus.HRDATA_S1    = 32'h1111_1111;
        bus.HRDATA_S2    = 32'h2222_2222;
        bus.HRDATA_S3    = 32'h3333_3333;
        bus.HRESP_S0     = 2'b00;
        bus.HRESP_S1     = 2'b00;
        bus.HRESP_S2     = 2'b00;
        bus.HRESP_S3     = 2'b00;
        apply_stimulus(32'h3000_0000, T_IDLE);
        #1;

        // Reset state; HSEL follows HADDR even in reset
        check_output("rst_hsel", sel_vec(), 32'h8);
        check_output("rst_hready", bus.HREADY, 32'h1);
        check_output("rst_hresp", bus.HRESP, 32'h0);
`ifdef DEFAULT_SLAVE_EN
        check_output("rst_hrdata", bus.HRDATA, 32'h0);
`else
        check_output("rst_hrdata", bus.HRDATA, 32'h0000_A000);
`endif
        @(posedge HCLK);
        #2;
        HRESET = 1'b0;

        // Decode and mux to slave 2
        apply_stimulus(32'h2000_0010, T_NONSEQ);
        check_output("dec_hsel_s2", sel_vec(), 32'h4);
        next_cycle();
        bus.HRDATA_S2 = 32'hDEAD_BEEF;
        apply_stimulus(32'h1000_0000, T_NONSEQ);
        check_output("mux_s2_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
        check_output("mux_s2_hresp", bus.HRESP, 32'h0);
        check_output("dec_hsel_s1", sel_vec(), 32'h2);
        next_cycle();

        // Slave 1 inserts three wait states while the address moves to region 3
        bus.HREADYOUT_S1 = 1'b0;
        apply_stimulus(32'h3000_0000, T_NONSEQ);
        check_output("wait1_hready", bus.HREADY, 32'h0);
        check_output("wait1_hrdata", bus.HRDATA, 32'h1111_1111);
        check_output("wait1_hsel", sel_vec(), 32'h8);
        next_cycle();
        check_output("wait2_hready", bus.HREADY, 32'h0);
        check_output("wait2_hrdata", bus.HRDATA, 32'h1111_1111);
        next_cycle();
        check_output("wait3_hready", bus.HREADY, 32'h0);
        check_output("wait3_hrdata", bus.HRDATA, 32'h1111_1111);
        bus.HREADYOUT_S1 = 1'b1;
        #1;
        check_output("wait_done_hready", bus.HREADY, 32'h1);
        next_cycle();
        check_output("s3_hrdata", bus.HRDATA, 32'h3333_3333);
        bus.HRESP_S3 = 2'b10;
        #1;
        check_output("s3_retry_pass", bus.HRESP, 32'h2);
        bus.HRESP_S3 = 2'b11;
        #1;
        check_output("s3_split_pass", bus.HRESP, 32'h3);
        bus.HRESP_S3 = 2'b00;

`ifdef DEFAULT_SLAVE_EN
        // Single unmapped NONSEQ, followed by an IDLE to the same unmapped address
        apply_stimulus(32'h9000_0000, T_NONSEQ);
        check_output("unmap_hsel", sel_vec(), 32'h0);
        next_cycle();
        apply_stimulus(32'h9000_0000, T_IDLE);
        check_output("err1_hready", bus.HREADY, 32'h0);
        check_output("err1_hresp", bus.HRESP, 32'h1);
        check_output("err1_hrdata", bus.HRDATA, 32'h0);
        next_cycle();
        check_output("err2_hready", bus.HREADY, 32'h1);
        check_output("err2_hresp", bus.HRESP, 32'h1);
        next_cycle();
        check_output("idle_unmap_hready", bus.HREADY, 32'h1);
        check_output("idle_unmap_hresp", bus.HRESP, 32'h0);

        // Two back-to-back unmapped NONSEQs, then a mapped NONSEQ issued in ERR2
        apply_stimulus(32'h9000_0000, T_NONSEQ);
        next_cycle();
        check_output("b2b_a_err1_hready", bus.HREADY, 32'h0);
        check_output("b2b_a_err1_hresp", bus.HRESP, 32'h1);
        next_cycle();
        check_output("b2b_a_err2_hready", bus.HREADY, 32'h1);
        check_output("b2b_a_err2_hresp", bus.HRESP, 32'h1);
        next_cycle();
        check_output("b2b_b_err1_hready", bus.HREADY, 32'h0);
        check_output("b2b_b_err1_hresp", bus.HRESP, 32'h1);
        apply_stimulus(32'h2000_0000, T_NONSEQ);
        next_cycle();
        check_output("b2b_b_err2_hready", bus.HREADY, 32'h1);
        check_output("b2b_b_err2_hresp", bus.HRESP, 32'h1);
        next_cycle();
        check_output("after_err_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
        check_output("after_err_hresp", bus.HRESP, 32'h0);
        check_output("after_err_hready", bus.HREADY, 32'h1);
`else
        // Unmapped addresses land on slave 0 and carry its response unchanged
        apply_stimulus(32'h9000_0000, T_NONSEQ);
        check_output("unmap_hsel_s0", sel_vec(), 32'h1);
        next_cycle();
        bus.HREADYOUT_S0 = 1'b0;
        bus.HRESP_S0     = 2'b01;
        #1;
        check_output("s0_err_hready", bus.HREADY, 32'h0);
        check_output("s0_err_hresp", bus.HRESP, 32'h1);
        check_output("s0_err_hrdata", bus.HRDATA, 32'h0000_A000);
        bus.HREADYOUT_S0 = 1'b1;
        bus.HRESP_S0     = 2'b00;
        #1;
        check_output("s0_ok_hready", bus.HREADY, 32'h1);
        check_output("s0_ok_hresp", bus.HRESP, 32'h0);
        next_cycle();
        check_output("s0_hold_hresp", bus.HRESP, 32'h0);
        check_output("s0_hold_hrdata", bus.HRDATA, 32'h0000_A000);
`endif

        // Asynchronous reset while slave 2 is stalling the bus
        apply_stimulus(32'h2000_0004, T_NONSEQ);
        next_cycle();
        bus.HREADYOUT_S2 = 1'b0;
        #1;
        check_output("pre_rst_hready", bus.HREADY, 32'h0);
        check_output("pre_rst_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
        HRESET = 1'b1;
        #1;
        check_output("async_rst_hready", bus.HREADY, 32'h1);
        check_output("async_rst_hresp", bus.HRESP, 32'h0);
`ifdef DEFAULT_SLAVE_EN
        check_output("async_rst_hrdata", bus.HRDATA, 32'h0);
`else
        check_output("async_rst_hrdata", bus.HRDATA, 32'h0000_A000);
`endif
        next_cycle();
        HRESET = 1'b0;
        bus.HREADYOUT_S2 = 1'b1;
        apply_stimulus(32'h1000_0000, T_NONSEQ);
        next_cycle();
        check_output("post_rst_hrdata", bus.HRDATA, 32'h1111_1111);
        check_output("post_rst_hready", bus.HREADY, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
